// File: rtl/iob_spi_flash_rdbuf_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iob_spi_flash_rdbuf_if                                           |
// | Cache-side read port and SPI flash controller request port.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface iob_spi_flash_rdbuf_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_ready_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              fl_valid_o;
  logic [ADDR_W-1:0] fl_addr_o;
  logic              fl_ready_i;
  logic [DATA_W-1:0] fl_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, fl_ready_i, fl_data_i,
    output req_ready_o, rdata_o, rvalid_o, fl_valid_o, fl_addr_o
  );

  modport master (
    output req_valid_i, req_addr_i, fl_ready_i, fl_data_i,
    input  req_ready_o, rdata_o, rvalid_o, fl_valid_o, fl_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_spi_flash_rdbuf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iob_spi_flash_rdbuf                                              |
// | Single-line read buffer in front of the SPI flash controller.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module iob_spi_flash_rdbuf #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             inv_i,
  iob_spi_flash_rdbuf_if.slave  bus
);
  localparam int c_IDX_W = $clog2(LINE_WORDS);
  localparam int c_TAG_W = ADDR_W - c_IDX_W - 2;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_data [LINE_WORDS];
  logic [c_TAG_W-1:0]  r_tag, w_tag_nxt;
  logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [c_IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic                r_line_valid, w_line_valid_nxt;
  logic                r_inv_pend, w_inv_pend_nxt;
  logic                r_fl_valid;
  logic [ADDR_W-1:0]   r_fl_addr;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic [c_IDX_W-1:0]  w_req_idx;
  logic [c_TAG_W-1:0]  w_req_tag;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0]   w_resp_data;
  logic                w_accept, w_hit, w_fl_done, w_last;
  logic                w_unused_addr;

  assign w_req_idx     = bus.req_addr_i[c_IDX_W+1:2];
  assign w_req_tag     = bus.req_addr_i[ADDR_W-1:c_IDX_W+2];
  assign w_unused_addr = ^bus.req_addr_i[1:0];
  assign w_accept      = (r_state == ST_IDLE) && bus.req_valid_i;
  assign w_hit         = r_line_valid && (r_tag == w_req_tag) && !inv_i;
  assign w_fl_done     = (r_state == ST_ISSUE) && bus.fl_ready_i;
  assign w_last        = (r_cnt == c_LAST);

  // The last fill word lands in r_data on the same edge RESP is entered, so bypass it.
  assign w_rd_idx    = (r_state == ST_IDLE) ? w_req_idx : r_idx;
  assign w_resp_data = (w_fl_done && (r_cnt == r_idx)) ? bus.fl_data_i : r_data[w_rd_idx];

  always_comb begin
    w_state_nxt      = r_state;
    w_tag_nxt        = r_tag;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_line_valid_nxt = r_line_valid;
    w_inv_pend_nxt   = r_inv_pend;
    case (r_state)
      ST_IDLE: begin
        if (inv_i) w_line_valid_nxt = 1'b0;
        if (w_accept) begin
          w_idx_nxt = w_req_idx;
          if (w_hit) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_tag_nxt        = w_req_tag;
            w_cnt_nxt        = '0;
            w_line_valid_nxt = 1'b0;
            w_state_nxt      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (inv_i) w_inv_pend_nxt = 1'b1;
        if (bus.fl_ready_i) begin
          if (w_last) begin
            w_line_valid_nxt = !(r_inv_pend || inv_i);
            w_state_nxt      = ST_RESP;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (inv_i) w_inv_pend_nxt = 1'b1;
        w_state_nxt = ST_ISSUE;
      end
      ST_RESP: begin
        if (inv_i) w_line_valid_nxt = 1'b0;
        w_inv_pend_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_line_valid <= 1'b0;
      r_inv_pend   <= 1'b0;
      r_fl_valid   <= 1'b0;
      r_fl_addr    <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      for (int i = 0; i < LINE_WORDS; i++) r_data[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tag        <= w_tag_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_line_valid <= w_line_valid_nxt;
      r_inv_pend   <= w_inv_pend_nxt;
      if (w_fl_done) r_data[r_cnt] <= bus.fl_data_i;
      // Outputs are decoded from the next state so they are registered yet timely.
      r_fl_valid <= (w_state_nxt == ST_ISSUE);
      if (w_state_nxt == ST_ISSUE) r_fl_addr <= {w_tag_nxt, w_cnt_nxt, 2'b00};
      r_rvalid <= (w_state_nxt == ST_RESP);
      if (w_state_nxt == ST_RESP) r_rdata <= w_resp_data;
    end
  end

  assign bus.req_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign bus.fl_valid_o  = r_fl_valid;
  assign bus.fl_addr_o   = r_fl_addr;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.rdata_o     = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_iob_spi_flash_rdbuf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_iob_spi_flash_rdbuf                                           |
// | Directed and randomized reads against a line-buffer model.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_iob_spi_flash_rdbuf;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int LINE_WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv = 1'b0;

  iob_spi_flash_rdbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_spi_flash_rdbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .inv_i (inv),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model of the buffered line.
  bit          m_valid = 1'b0;
  logic [19:0] m_tag   = '0;
  logic [31:0] m_line [LINE_WORDS];

  int          g_lat = 5;        // 0 selects random controller latency
  bit          g_salt_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_read(input logic [23:0] addr, input bit inv_req,
                         input int inv_word, input int rst_word);
    logic [19:0] tag;
    int          idx;
    logic [23:0] base;
    logic [31:0] salt;
    logic [31:0] d;
    bit          hit;
    bit          inv_seen;
    int          lat;
    tag  = addr[23:4];
    idx  = int'(addr[3:2]);
    base = {addr[23:4], 4'h0};
    hit  = m_valid && (m_tag == tag) && !inv_req;
    inv_seen = inv_req;

    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    inv = inv_req;
    #1 check("req_ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 24'($urandom);
    inv = 1'b0;

    if (hit) begin
      check("hit_rvalid", 32'(bus.rvalid_o), 32'd1);
      check("hit_rdata", bus.rdata_o, m_line[idx]);
      check("hit_no_fl", 32'(bus.fl_valid_o), 32'd0);
      @(negedge clk);
      check("hit_rvalid_drop", 32'(bus.rvalid_o), 32'd0);
      return;
    end

    m_valid = 1'b0;
    m_tag   = tag;
    salt    = g_salt_en ? $urandom : 32'h0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      check("fl_valid_up", 32'(bus.fl_valid_o), 32'd1);
      check("fl_addr", 32'(bus.fl_addr_o), 32'(base + 24'(4 * k)));
      lat = (g_lat == 0) ? int'($urandom_range(1, 4)) : g_lat;
      for (int c = 1; c <= lat; c++) begin
        if (k == rst_word && c == 1) begin
          rst = 1'b1;
          #1 check("rst_ready", 32'(bus.req_ready_o), 32'd0);
          @(negedge clk);
          check("rst_fl_valid", 32'(bus.fl_valid_o), 32'd0);
          check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
          check("rst_rdata", bus.rdata_o, 32'd0);
          check("rst_ready_hold", 32'(bus.req_ready_o), 32'd0);
          rst = 1'b0;
          m_valid = 1'b0;
          return;
        end
        if (k == inv_word && c == 1) begin
          inv = 1'b1;
          inv_seen = 1'b1;
        end
        if (c == lat) begin
          d = {8'h0, base + 24'(4 * k)} ^ 32'hA5A5_0000 ^ salt;
          m_line[k] = d;
          bus.fl_ready_i = 1'b1;
          bus.fl_data_i  = d;
        end
        @(negedge clk);
        inv = 1'b0;
        bus.fl_ready_i = 1'b0;
        bus.fl_data_i  = $urandom;
        if (c < lat) check("fl_valid_hold", 32'(bus.fl_valid_o), 32'd1);
      end
      check("fl_valid_fall", 32'(bus.fl_valid_o), 32'd0);
      if (k < LINE_WORDS - 1) begin
        check("gap_no_rvalid", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk);
      end
    end
    check("miss_rvalid", 32'(bus.rvalid_o), 32'd1);
    check("miss_rdata", bus.rdata_o, m_line[idx]);
    m_valid = !inv_seen;
    @(negedge clk);
    check("miss_rvalid_drop", 32'(bus.rvalid_o), 32'd0);
  endtask

  task automatic do_inv();
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [23:0] a;
    for (int i = 0; i < LINE_WORDS; i++) m_line[i] = '0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.fl_ready_i  = 1'b0;
    bus.fl_data_i   = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_low", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("reset_fl_valid", 32'(bus.fl_valid_o), 32'd0);
    check("reset_rdata", bus.rdata_o, 32'd0);
    check("reset_fl_addr", 32'(bus.fl_addr_o), 32'd0);
    check("reset_ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);

    // Directed scenarios, controller latency 5, data = addr ^ 0xA5A50000.
    do_read(24'h000104, 1'b0, -1, -1);
    check("cold_miss_value", bus.rdata_o, 32'hA5A5_0104);
    do_read(24'h00010C, 1'b0, -1, -1);
    check("hit_10c_value", bus.rdata_o, 32'hA5A5_010C);
    do_read(24'h000100, 1'b0, -1, -1);
    check("hit_100_value", bus.rdata_o, 32'hA5A5_0100);
    do_read(24'h000200, 1'b0, -1, -1);
    check("tag_change_value", bus.rdata_o, 32'hA5A5_0200);
    do_read(24'h000300, 1'b0, 1, -1);
    check("inv_fill_value", bus.rdata_o, 32'hA5A5_0300);
    check("inv_fill_model", 32'(m_valid), 32'd0);
    do_read(24'h000304, 1'b0, -1, -1);
    do_read(24'h000400, 1'b0, -1, 2);
    do_read(24'h000404, 1'b0, -1, -1);
    do_read(24'h000408, 1'b0, -1, -1);
    do_read(24'h00040C, 1'b1, -1, -1);

    // Randomized traffic over a small set of tags to mix hits and misses.
    g_lat = 0;
    g_salt_en = 1'b1;
    for (int n = 0; n < 90; n++) begin
      a = {($urandom_range(0, 1) == 1) ? 20'hFFFF0 : 20'h00000, 4'h0};
      a[5:4] = 2'($urandom_range(0, 3));
      a[3:0] = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 19));
      if (r == 0)      do_inv();
      else if (r < 3)  do_read(a, 1'b1, -1, -1);
      else if (r < 5)  do_read(a, 1'b0, int'($urandom_range(0, LINE_WORDS - 1)), -1);
      else if (r == 5) do_read(a, 1'b0, -1, int'($urandom_range(0, LINE_WORDS - 1)));
      else             do_read(a, 1'b0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
